// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1:2 buffered demultiplexer.
// Optional feature macro: DEMUX_STATS_EN (per-channel routed-word counters).
package demux_pkg;

    localparam int DATA_W = 32;

    localparam logic SEL_OUT1 = 1'b0;
    localparam logic SEL_OUT2 = 1'b1;

    // Pointer width for a power-of-two FIFO depth.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/demux_1_2_buf_if.sv
// Producer and two-consumer handshake bundle for demux_1_2_buf.
// The slave modport is the demux side; the master modport is the producer/consumer side.
// cnt1/cnt2 carry live values only when DEMUX_STATS_EN is defined.
interface demux_1_2_buf_if
    import demux_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out2_valid;
    logic             out2_ready;
    logic [WIDTH-1:0] out2_data;
    logic [31:0]      cnt1;
    logic [31:0]      cnt2;

    modport slave (
        input  in_valid, in_data, in_sel, out1_ready, out2_ready,
        output in_ready, out1_valid, out1_data, out2_valid, out2_data, cnt1, cnt2
    );

    modport master (
        output in_valid, in_data, in_sel, out1_ready, out2_ready,
        input  in_ready, out1_valid, out1_data, out2_valid, out2_data, cnt1, cnt2
    );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; head word is read combinationally
// and forced to zero while empty. Push while full and pop while empty are ignored.
module sync_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    output logic                   full,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic [ptr_w(DEPTH):0]  count
);

    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_en;
    logic             pop_en;

    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage, pointers (wrapping modulo DEPTH) and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux_1_2_buf.sv
// 1:2 buffered demultiplexer: steers each accepted word into the out1 or out2
// FIFO by in_sel, so a stalled consumer never blocks the other channel.
// Optional feature macro: DEMUX_STATS_EN adds wrapping 32-bit routed-word counters.
module demux_1_2_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    demux_1_2_buf_if.slave   bus
);

    localparam int PW = ptr_w(DEPTH);

    logic          accept;
    logic          push1;
    logic          push2;
    logic          pop1;
    logic          pop2;
    logic          full1;
    logic          full2;
    logic          empty1;
    logic          empty2;
    logic [PW:0]   count1;
    logic [PW:0]   count2;

    // in_ready depends only on in_sel and registered occupancy, never on out*_ready.
    assign bus.in_ready = (bus.in_sel == SEL_OUT2) ? !full2 : !full1;
    assign accept       = bus.in_valid && bus.in_ready;
    assign push1        = accept && (bus.in_sel == SEL_OUT1);
    assign push2        = accept && (bus.in_sel == SEL_OUT2);
    assign pop1         = bus.out1_ready && !empty1;
    assign pop2         = bus.out2_ready && !empty2;

    assign bus.out1_valid = (count1 != '0);
    assign bus.out2_valid = (count2 != '0);

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (push1),
        .din   (bus.in_data),
        .full  (full1),
        .pop   (pop1),
        .dout  (bus.out1_data),
        .empty (empty1),
        .count (count1)
    );

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo2 (
        .clk   (clk),
        .rst   (rst),
        .push  (push2),
        .din   (bus.in_data),
        .full  (full2),
        .pop   (pop2),
        .dout  (bus.out2_data),
        .empty (empty2),
        .count (count2)
    );

`ifdef DEMUX_STATS_EN
    logic [31:0] cnt1_q;
    logic [31:0] cnt2_q;

    // Count accepted words per channel; counters wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else begin
            if (push1) cnt1_q <= cnt1_q + 32'd1;
            if (push2) cnt2_q <= cnt2_q + 32'd1;
        end
    end

    assign bus.cnt1 = cnt1_q;
    assign bus.cnt2 = cnt2_q;
`else
    assign bus.cnt1 = '0;
    assign bus.cnt2 = '0;
`endif

endmodule

// File: tb/tb_demux_1_2_buf.sv
// Self-checking bench for demux_1_2_buf: directed scenarios plus a random phase,
// all checked against a queue-based channel model.
// Honours DEMUX_STATS_EN for the counter expectations.
module tb_demux_1_2_buf;

    localparam int DEPTH = 2;
`ifdef DEMUX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic rst;

    demux_1_2_buf_if #(.WIDTH(32)) bus ();

    demux_1_2_buf #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [31:0] got1[$];
    logic [31:0] got2[$];
    logic [31:0] m_cnt1;
    logic [31:0] m_cnt2;
    logic        acc;
    int          idx;
    int          budget;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
        chk("out1_data",  bus.out1_data, (q1.size() != 0) ? q1[0] : 32'd0);
        chk("out2_valid", 32'(bus.out2_valid), 32'(q2.size() != 0));
        chk("out2_data",  bus.out2_data, (q2.size() != 0) ? q2[0] : 32'd0);
        chk("cnt1", bus.cnt1, STATS ? m_cnt1 : 32'd0);
        chk("cnt2", bus.cnt2, STATS ? m_cnt2 : 32'd0);
    endtask

    // One clock cycle: drive, check in_ready, record actual pops, advance the model.
    task automatic cyc(input logic v, input logic s, input logic [31:0] d,
                       input logic r1, input logic r2, output logic accepted);
        logic exp_rdy;
        logic p1;
        logic p2;
        bus.in_valid   = v;
        bus.in_sel     = s;
        bus.in_data    = d;
        bus.out1_ready = r1;
        bus.out2_ready = r2;
        #1;
        exp_rdy = s ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        accepted = v && exp_rdy;
        p1 = r1 && (q1.size() != 0);
        p2 = r2 && (q2.size() != 0);
        if (p1) got1.push_back(bus.out1_data);
        if (p2) got2.push_back(bus.out2_data);
        @(posedge clk);
        #1;
        if (p1) void'(q1.pop_front());
        if (p2) void'(q2.pop_front());
        if (accepted) begin
            if (s) begin
                q2.push_back(d);
                m_cnt2 = m_cnt2 + 32'd1;
            end else begin
                q1.push_back(d);
                m_cnt1 = m_cnt1 + 32'd1;
            end
        end
        check_all();
    endtask

    task automatic clear_model();
        q1.delete();
        q2.delete();
        got1.delete();
        got2.delete();
        m_cnt1 = '0;
        m_cnt2 = '0;
    endtask

    // Reset asserted away from any clock edge; buffered words must vanish at once.
    task automatic async_reset();
        bus.in_valid   = 1'b0;
        bus.out1_ready = 1'b0;
        bus.out2_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
        chk("rst_out2_valid", 32'(bus.out2_valid), 32'd0);
        chk("rst_out1_data", bus.out1_data, 32'd0);
        chk("rst_out2_data", bus.out2_data, 32'd0);
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_sel     = 1'b0;
        bus.in_data    = '0;
        bus.out1_ready = 1'b0;
        bus.out2_ready = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset then idle
        check_all();
        chk("idle_in_ready0", 32'(bus.in_ready), 32'd1);
        bus.in_sel = 1'b1;
        #1;
        chk("idle_in_ready1", 32'(bus.in_ready), 32'd1);

        // Single steer
        cyc(1'b1, 1'b0, 32'd200, 1'b0, 1'b0, acc);
        chk("steer1_valid", 32'(bus.out1_valid), 32'd1);
        chk("steer1_data", bus.out1_data, 32'd200);
        chk("steer1_v2", 32'(bus.out2_valid), 32'd0);
        cyc(1'b1, 1'b1, 32'd345, 1'b0, 1'b0, acc);
        chk("steer2_data", bus.out2_data, 32'd345);

        // Two words buffered, then asynchronous reset
        async_reset();

        // Full back-pressure on out1 while out2 keeps flowing
        cyc(1'b1, 1'b0, 32'd10, 1'b0, 1'b0, acc);
        cyc(1'b1, 1'b0, 32'd11, 1'b0, 1'b0, acc);
        bus.in_sel   = 1'b0;
        bus.in_valid = 1'b1;
        #1;
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        cyc(1'b1, 1'b1, 32'd12, 1'b0, 1'b0, acc);
        chk("full_out2_data", bus.out2_data, 32'd12);
        chk("full_out1_head", bus.out1_data, 32'd10);

        // Full channel plus pop: word 99 must not be admitted this cycle
        cyc(1'b1, 1'b0, 32'd99, 1'b1, 1'b0, acc);
        chk("fullpop_acc", 32'(acc), 32'd0);
        chk("fullpop_head", bus.out1_data, 32'd11);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, acc);

        // Simultaneous push/pop on a non-full channel
        cyc(1'b1, 1'b0, 32'd10, 1'b0, 1'b0, acc);
        cyc(1'b1, 1'b0, 32'd11, 1'b1, 1'b0, acc);
        chk("pushpop_head", bus.out1_data, 32'd11);
        bus.in_valid = 1'b0;
        bus.in_sel   = 1'b0;
        #1;
        chk("pushpop_not_full", 32'(bus.in_ready), 32'd1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, acc);

        // Wrap and ordering: 0..9 alternating channels, random consumer ready
        async_reset();
        idx    = 0;
        budget = 0;
        while ((idx < 10 || q1.size() != 0 || q2.size() != 0) && budget < 300) begin
            cyc(idx < 10, 1'(idx), 32'(idx), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), acc);
            if (acc) idx++;
            budget++;
        end
        chk("stream_done", 32'(idx == 10 && q1.size() == 0 && q2.size() == 0), 32'd1);
        chk("stream_n1", 32'(got1.size()), 32'd5);
        chk("stream_n2", 32'(got2.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("stream_out1", (i < got1.size()) ? got1[i] : 32'hDEAD_BEEF, 32'(2 * i));
            chk("stream_out2", (i < got2.size()) ? got2[i] : 32'hDEAD_BEEF, 32'(2 * i + 1));
        end
        chk("stream_cnt1", bus.cnt1, STATS ? 32'd5 : 32'd0);
        chk("stream_cnt2", bus.cnt2, STATS ? 32'd5 : 32'd0);

        // Counter wrap
`ifdef DEMUX_STATS_EN
        force dut.cnt1_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt1_q;
        m_cnt1 = 32'hFFFF_FFFF;
        #1;
        chk("wrap_preload", bus.cnt1, 32'hFFFF_FFFF);
`endif
        cyc(1'b1, 1'b0, 32'd77, 1'b1, 1'b0, acc);
        chk("wrap_cnt1", bus.cnt1, 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, acc);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_1_2_buf.md
Name: demux_1_2_buf

Overview:
- Inverse of the datapath 2:1 select. Accepts one 32-bit word stream and steers each word to one of two consumers, chosen by a per-word select bit.
- Each consumer has its own small FIFO, so one stalled consumer never blocks words bound for the other once they are enqueued.
- Used in the MIPS datapath to return shared memory-port responses to either the fetch path (out1) or the load/store path (out2).

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per output FIFO. Power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  word can be accepted this cycle.
- in_data  input  WIDTH  word.
- in_sel  input  1  0 -> out1, 1 -> out2.
- out1_valid  output  1  out1 FIFO non-empty.
- out1_ready  input  1  consumer 1 takes the head word.
- out1_data  output  WIDTH  out1 head word.
- out2_valid  output  1  out2 FIFO non-empty.
- out2_ready  input  1  consumer 2 takes the head word.
- out2_data  output  WIDTH  out2 head word.
- cnt1  output  32  words routed to out1 (stats feature only).
- cnt2  output  32  words routed to out2 (stats feature only).

Behaviour:
- Reset: clk is single; rst is asynchronous, active-high. All pointers, occupancy counts, storage and stat counters clear to 0. out1_valid = out2_valid = 0, out1_data = out2_data = 0, in_ready = 1.
- Reset asserted mid-operation discards all buffered words immediately, with no clock edge required.
- Per channel, a FIFO keeps write pointer, read pointer and occupancy count. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- in_ready = in_sel ? !full2 : !full1. It is a combinational function of in_sel and the registered occupancies only; it never depends on out*_ready.
- Accept: in_valid && in_ready at a rising edge writes in_data into the FIFO chosen by in_sel, and that FIFO's write pointer increments.
- Output: outN_valid = (countN != 0). outN_data = storage at the read pointer, combinational from registers. outN_data is 0 when the FIFO is empty.
- Dequeue: outN_valid && outN_ready at a rising edge advances the read pointer. outN_ready while empty is ignored.
- Latency: a word accepted at edge k is visible on outN at edge k+1 (one cycle). There is no combinational in->out bypass.
- Ordering: strict FIFO order within each channel. No ordering is implied between channels.
- Enqueue and dequeue on the same channel in the same cycle leave the count unchanged and move both pointers.
  - When the FIFO is full, in_ready is already 0, so a same-cycle dequeue does not admit a new word until the next cycle.
- Activity on the two channels is fully independent: enqueue on one while dequeuing the other is legal.
- in_sel is sampled only when in_valid && in_ready. With in_valid = 0, in_sel and in_data are don't-care.
- The producer must hold in_data and in_sel stable while in_valid && !in_ready.

Optional Feature:
- Macro DEMUX_STATS_EN.
- Defined:
  - cnt1 and cnt2 increment by 1 on each accepted word for their channel.
  - Counters are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on rst.
- Undefined: cnt1 and cnt2 are tied to 0 and no counter flops exist. Port list is identical in both builds.

Decomposition:
- Package demux_pkg:
  - DATA_W = 32.
  - Function ptr_w(depth) returning $clog2(depth).
  - Constants SEL_OUT1 = 1'b0 and SEL_OUT2 = 1'b1.
- Sub-module sync_fifo, parameterised by WIDTH and DEPTH, with push/full/pop/empty/count. Instantiated twice.
- Top level holds only the steering logic, in_ready selection and stat counters.

Test Plan:
- Reset then idle:
  - in_ready = 1, both outN_valid = 0, both outN_data = 0.
  - Assert rst mid-run with 2 words buffered -> both valid drop with no clock edge.
- Single steer:
  - in_data = 200, in_sel = 0, accepted -> next cycle out1_valid = 1, out1_data = 200, out2_valid = 0.
  - Then in_data = 345, in_sel = 1 -> out2_data = 345.
- Full back-pressure:
  - out1_ready = 0; push 10, 11 to out1 -> in_ready drops with in_sel = 0.
  - With in_sel = 1, in_ready = 1 and 12 reaches out2 while out1 stays full.
- Simultaneous push/pop on a non-full channel:
  - count 1 holding 10, push 11 while popping -> count stays 1, next head = 11.
  - Full channel plus pop -> in_ready stays 0 that cycle.
- Wrap and ordering: stream 0..9 alternating sel with random ready -> out1 sees 0,2,4,6,8 and out2 sees 1,3,5,7,9, in order.
- DEMUX_STATS_EN:
  - After the previous scenario, cnt1 = 5 and cnt2 = 5.
  - Preload cnt1 = 0xFFFFFFFF via force, push one word -> cnt1 = 0.
  - Without the macro, cnt1 and cnt2 remain 0.
